reg_dest_decoder_5_32: RTL
==========================

// Module: reg_dest_decoder_5_32
// PURPOSE
//  Registered 5:32 destination-register decoder. Turns a 5-bit register number into a
//  one-hot 32-bit write-enable for the register file. It is the inverse of the 32:5
//  priority-code path. It sits between writeback issue and the register file, with a
//  valid/ready handshake on both sides and a 2-entry buffer (output reg + skid) so
//  that register-file stalls never drop a write. It also keeps a sticky
//  written-register mask and a count of suppressed R0 writes.
// PARAMETERS
//  R0_DROP    1  1: enabled writes to R0 are consumed but never emitted; 0: R0 decoded normally
//  CNT_W      8  width of drop_cnt
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      request valid
//  in_ready      out  1      block can accept a request this cycle
//  in_code       in   5      destination register number 0..31
//  in_en         in   1      1 = real write; 0 = no-op entry (passes through, one-hot = 0)
//  out_valid     out  1      output entry valid
//  out_ready     in   1      register file accepts the entry
//  out_onehot    out  32     one-hot write enable, bit in_code set (all-zero if in_en=0)
//  out_code      out  5      in_code carried alongside for debug/forwarding
//  mask_clr      in   1      synchronous clear of written_mask
//  written_mask  out  32     sticky OR of every out_onehot that fired
//  drop_cnt      out  CNT_W  saturating count of R0 writes suppressed (R0_DROP=1)
// BEHAVIOUR
//  - Reset (rst_n=0, async): O and S stages empty, out_valid=0, out_onehot=0, out_code=0,
//    in_ready=1 (after reset release), written_mask=0, drop_cnt=0.
//  - accept = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready = ~S_valid (registered, no combinational path from out_ready).
//  - Decode: onehot = in_en ? (32'b1 << in_code) : 0. Every code 0..31 maps to its own bit.
//    No default/X output.
//  - drop = accept & in_en & (in_code==0) & R0_DROP. A dropped request completes the
//    handshake, creates no entry, and increments drop_cnt (saturating at all-ones).
//  - Per cycle, with O free = ~O_valid | out_fire:
//      O free & S_valid      : O <= S, S empties; a same-cycle accept is stored in S.
//      O free & ~S_valid     : O <= accepted non-dropped request (else O empties).
//      ~O free               : an accepted non-dropped request goes to S.
//  - Latency: request accepted in cycle N appears on out_* in cycle N+1 when unstalled.
//    Throughput is 1 per cycle. Order is strictly preserved. No entry is lost or duplicated.
//  - out_* hold stable while out_valid & ~out_ready.
//  - written_mask: next = (mask_clr ? 0 : mask) | (out_fire ? out_onehot : 0).
//    A clear in the same cycle as a fire leaves only that fire's bit.
//  - drop_cnt is not cleared by mask_clr; only reset clears it.
//  - Reset mid-operation: both buffered entries are discarded immediately (async). No
//    out_valid in the cycle after reset deasserts.
// TESTING
//  1. Reset, then send code 5, in_en=1, out_ready=1 -> next cycle out_valid=1,
//     out_onehot=32'h0000_0020, out_code=5; written_mask=32'h20 after fire.
//  2. Sweep codes 1..31 back-to-back, out_ready=1 -> one entry per cycle, onehot=1<<code
//     (code 30 -> 32'h4000_0000, 31 -> 32'h8000_0000); in_ready stays 1.
//  3. out_ready=0, send codes 3,7,9 -> 3 in O, 7 in S, in_ready=0 with 9 held. Raise
//     out_ready -> outputs 3,7,9 in order on consecutive cycles; no loss.
//  4. R0_DROP=1: send code 0 en=1 -> accepted, no out_valid, drop_cnt=1. Send code 0
//     en=0 -> entry emitted with onehot=0. Force 2^CNT_W drops -> drop_cnt saturates.
//  5. mask_clr in the same cycle as a code-12 fire -> written_mask=32'h0000_1000.
//  6. Fill both stages, assert rst_n=0 mid-stall -> out_valid=0 and mask=0 immediately;
//     in_ready=1 after release.

Source files
------------

// File: rtl/reg_dest_decoder_5_32.sv
// Registered 5:32 destination-register decoder with valid/ready handshakes on both sides.
// A two-deep buffer (output stage + skid stage) absorbs register-file stalls without losing writes.
module reg_dest_decoder_5_32 #(
    parameter bit R0_DROP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_onehot,
    output logic [4:0]       out_code,
    input  logic             mask_clr,
    output logic [31:0]      written_mask,
    output logic [CNT_W-1:0] drop_cnt
);

    logic             o_valid_r;
    logic [31:0]      o_onehot_r;
    logic [4:0]       o_code_r;
    logic             s_valid_r;
    logic [31:0]      s_onehot_r;
    logic [4:0]       s_code_r;
    logic [31:0]      mask_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic             o_valid_nx_s;
    logic [31:0]      o_onehot_nx_s;
    logic [4:0]       o_code_nx_s;
    logic             s_valid_nx_s;
    logic [31:0]      s_onehot_nx_s;
    logic [4:0]       s_code_nx_s;
    logic [31:0]      mask_nx_s;
    logic [CNT_W-1:0] drop_cnt_nx_s;

    logic             accept_s;
    logic             drop_s;
    logic             store_s;
    logic             fire_s;
    logic             o_free_s;
    logic [31:0]      dec_s;

    function automatic logic [31:0] decode(input logic en, input logic [4:0] code);
        logic [31:0] oh;
        if (en) begin
            oh = 32'h0000_0001 << code;
        end else begin
            oh = 32'h0000_0000;
        end
        return oh;
    endfunction

    // Handshake qualification, buffer steering, sticky mask and drop counter next-state.
    always_comb begin
        accept_s = in_valid & ~s_valid_r;
        dec_s    = decode(in_en, in_code);
        drop_s   = accept_s & in_en & (in_code == 5'd0) & R0_DROP;
        store_s  = accept_s & ~drop_s;
        fire_s   = o_valid_r & out_ready;
        o_free_s = ~o_valid_r | fire_s;

        o_valid_nx_s  = o_valid_r;
        o_onehot_nx_s = o_onehot_r;
        o_code_nx_s   = o_code_r;
        s_valid_nx_s  = s_valid_r;
        s_onehot_nx_s = s_onehot_r;
        s_code_nx_s   = s_code_r;

        if (o_free_s) begin
            if (s_valid_r) begin
                // Skid entry is older than any new request, so it moves up first.
                o_valid_nx_s  = 1'b1;
                o_onehot_nx_s = s_onehot_r;
                o_code_nx_s   = s_code_r;
                s_valid_nx_s  = store_s;
                s_onehot_nx_s = store_s ? dec_s : 32'h0000_0000;
                s_code_nx_s   = store_s ? in_code : 5'd0;
            end else begin
                o_valid_nx_s  = store_s;
                o_onehot_nx_s = store_s ? dec_s : 32'h0000_0000;
                o_code_nx_s   = store_s ? in_code : 5'd0;
            end
        end else begin
            if (store_s) begin
                s_valid_nx_s  = 1'b1;
                s_onehot_nx_s = dec_s;
                s_code_nx_s   = in_code;
            end else begin
                s_valid_nx_s  = s_valid_r;
            end
        end

        mask_nx_s = (mask_clr ? 32'h0000_0000 : mask_r) | (fire_s ? o_onehot_r : 32'h0000_0000);

        if (drop_s && !(&drop_cnt_r)) begin
            drop_cnt_nx_s = drop_cnt_r + CNT_W'(1);
        end else begin
            drop_cnt_nx_s = drop_cnt_r;
        end
    end

    // State registers; reset discards both buffered entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_r  <= 1'b0;
            o_onehot_r <= 32'h0000_0000;
            o_code_r   <= 5'd0;
            s_valid_r  <= 1'b0;
            s_onehot_r <= 32'h0000_0000;
            s_code_r   <= 5'd0;
            mask_r     <= 32'h0000_0000;
            drop_cnt_r <= '0;
        end else begin
            o_valid_r  <= o_valid_nx_s;
            o_onehot_r <= o_onehot_nx_s;
            o_code_r   <= o_code_nx_s;
            s_valid_r  <= s_valid_nx_s;
            s_onehot_r <= s_onehot_nx_s;
            s_code_r   <= s_code_nx_s;
            mask_r     <= mask_nx_s;
            drop_cnt_r <= drop_cnt_nx_s;
        end
    end

    assign in_ready     = ~s_valid_r;
    assign out_valid    = o_valid_r;
    assign out_onehot   = o_onehot_r;
    assign out_code     = o_code_r;
    assign written_mask = mask_r;
    assign drop_cnt     = drop_cnt_r;

endmodule
